// File: rtl/mod_gen_pkg.sv
// Shared encodings and reset constants for the modulation clock generator.
package mod_gen_pkg;

   localparam logic [1:0] MODE_OFF   = 2'd0;
   localparam logic [1:0] MODE_CONT  = 2'd1;
   localparam logic [1:0] MODE_BURST = 2'd2;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_BURST = 2'd2
   } state_e;

   localparam int unsigned RST_PERIOD = 3;
   localparam int unsigned RST_DUTY   = 2;
   localparam int unsigned MIN_PERIOD = 3;

endpackage

// File: rtl/mod_phase_cmp.sv
// Registered phase-shifted duty compare producing one light-source clock bit.
module mod_phase_cmp #(
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [CNT_W-1:0] cnt,
   input  logic [CNT_W-1:0] per,
   input  logic [CNT_W-1:0] ph,
   input  logic [CNT_W-1:0] duty,
   output logic             clkl
);

   localparam int unsigned SW = CNT_W + 1;

   logic [SW-1:0] rel_c;
   logic          clkl_d, clkl_q;

   // Position within the shifted period, wrapping modulo per+1.
   always_comb begin
      rel_c = '0;
      if (cnt >= ph) rel_c = SW'(cnt) - SW'(ph);
      else           rel_c = SW'(cnt) + SW'(per) + SW'(1) - SW'(ph);
      clkl_d = en && (rel_c < SW'(duty));
   end

   always_ff @(posedge clk) begin
      if (rst) clkl_q <= 1'b0;
      else     clkl_q <= clkl_d;
   end

   assign clkl = clkl_q;

endmodule

// File: rtl/mod_clkgen_multi.sv
// Multi-channel modulation clock generator: FSM, period counter, double-buffered
// config and CLK/CLKN decode; CLKL channels come from mod_phase_cmp instances.
module mod_clkgen_multi
   import mod_gen_pkg::*;
#(
   parameter int unsigned CNT_W   = 8,
   parameter int unsigned N_LIGHT = 2,
   parameter int unsigned DT_W    = 3,
   parameter int unsigned BURST_W = 16
) (
   input  logic                     USER_CLOCK,
   input  logic                     RESET,
   input  logic [1:0]               MODE,
   input  logic [CNT_W-1:0]         PERIOD,
   input  logic [CNT_W-1:0]         DUTY,
   input  logic [DT_W-1:0]          DEAD,
   input  logic [N_LIGHT*CNT_W-1:0] PHASE,
   input  logic [BURST_W-1:0]       BURST_LEN,
   input  logic                     CFG_LOAD,
   input  logic                     START,
   input  logic                     DRAIN_B,
   output logic                     CLK_MOD,
   output logic                     CLKN_MOD,
   output logic [N_LIGHT-1:0]       CLKL_MOD,
   output logic                     PERIOD_TICK,
   output logic                     CFG_ACK,
   output logic                     BUSY
);

   localparam int unsigned SW  = CNT_W + 1;
   localparam int unsigned PHW = N_LIGHT * CNT_W;

   state_e               state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [BURST_W-1:0]   burst_q, burst_d;
   logic [CNT_W-1:0]     per_a_q, per_a_d, duty_a_q, duty_a_d;
   logic [DT_W-1:0]      dead_a_q, dead_a_d;
   logic [PHW-1:0]       ph_a_q, ph_a_d;
   logic [CNT_W-1:0]     per_p_q, per_p_d, duty_p_q, duty_p_d;
   logic [DT_W-1:0]      dead_p_q, dead_p_d;
   logic [PHW-1:0]       ph_p_q, ph_p_d;
   logic                 dirty_q, dirty_d;
   logic                 clk_q, clk_d, clkn_q, clkn_d;
   logic                 tick_q, tick_d, ack_q, ack_d, busy_q, busy_d;

   logic [CNT_W-1:0]     per_in_c, duty_in_c;
   logic [PHW-1:0]       ph_in_c;
   logic                 run_c, wrap_c, en_c;
   logic [N_LIGHT-1:0]   clkl;

   // Clamp the programmed values as they are captured.
   always_comb begin
      per_in_c = (PERIOD < CNT_W'(MIN_PERIOD)) ? CNT_W'(MIN_PERIOD) : PERIOD;
      if (DUTY == '0)           duty_in_c = CNT_W'(1);
      else if (DUTY > per_in_c) duty_in_c = per_in_c;
      else                      duty_in_c = DUTY;
      ph_in_c = '0;
      for (int i = 0; i < N_LIGHT; i++) begin
         if (PHASE[i*CNT_W +: CNT_W] <= per_in_c)
            ph_in_c[i*CNT_W +: CNT_W] = PHASE[i*CNT_W +: CNT_W];
      end
   end

   assign run_c  = (state_q != ST_IDLE);
   assign wrap_c = run_c && (cnt_q == per_a_q);
   assign en_c   = run_c && DRAIN_B;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      burst_d  = burst_q;
      per_a_d  = per_a_q;
      duty_a_d = duty_a_q;
      dead_a_d = dead_a_q;
      ph_a_d   = ph_a_q;
      per_p_d  = per_p_q;
      duty_p_d = duty_p_q;
      dead_p_d = dead_p_q;
      ph_p_d   = ph_p_q;
      dirty_d  = dirty_q;
      ack_d    = 1'b0;

      // Active bank only changes at a period boundary or while idle.
      if (CFG_LOAD && wrap_c) begin
         per_a_d  = per_in_c;
         duty_a_d = duty_in_c;
         dead_a_d = DEAD;
         ph_a_d   = ph_in_c;
         per_p_d  = per_in_c;
         duty_p_d = duty_in_c;
         dead_p_d = DEAD;
         ph_p_d   = ph_in_c;
         dirty_d  = 1'b0;
         ack_d    = 1'b1;
      end else begin
         if (dirty_q && (wrap_c || !run_c)) begin
            per_a_d  = per_p_q;
            duty_a_d = duty_p_q;
            dead_a_d = dead_p_q;
            ph_a_d   = ph_p_q;
            dirty_d  = 1'b0;
            ack_d    = 1'b1;
         end
         if (CFG_LOAD) begin
            per_p_d  = per_in_c;
            duty_p_d = duty_in_c;
            dead_p_d = DEAD;
            ph_p_d   = ph_in_c;
            dirty_d  = 1'b1;
         end
      end

      if (!DRAIN_B) begin
         state_d = ST_IDLE;
         cnt_d   = '0;
         burst_d = '0;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               cnt_d = '0;
               if (MODE == MODE_CONT) begin
                  state_d = ST_RUN;
               end else if (MODE == MODE_BURST && START && BURST_LEN != '0) begin
                  state_d = ST_BURST;
                  burst_d = BURST_LEN;
               end
            end
            ST_RUN: begin
               if (wrap_c) begin
                  cnt_d = '0;
                  if (MODE != MODE_CONT) state_d = ST_IDLE;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            ST_BURST: begin
               if (wrap_c) begin
                  cnt_d   = '0;
                  burst_d = burst_q - BURST_W'(1);
                  if (burst_q == BURST_W'(1)) state_d = ST_IDLE;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            default: begin
               state_d = ST_IDLE;
               cnt_d   = '0;
               burst_d = '0;
            end
         endcase
      end

      // Output decode of the current counter; visible one cycle later.
      clk_d  = en_c && (SW'(cnt_q) < SW'(duty_a_q));
      clkn_d = en_c && (SW'(cnt_q) >= SW'(duty_a_q) + SW'(dead_a_q))
                    && (SW'(cnt_q) + SW'(dead_a_q) <= SW'(per_a_q));
      tick_d = en_c && (cnt_q == per_a_q);
      busy_d = en_c;
   end

   always_ff @(posedge USER_CLOCK) begin
      if (RESET) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         burst_q  <= '0;
         per_a_q  <= CNT_W'(RST_PERIOD);
         duty_a_q <= CNT_W'(RST_DUTY);
         dead_a_q <= '0;
         ph_a_q   <= '0;
         per_p_q  <= CNT_W'(RST_PERIOD);
         duty_p_q <= CNT_W'(RST_DUTY);
         dead_p_q <= '0;
         ph_p_q   <= '0;
         dirty_q  <= 1'b0;
         clk_q    <= 1'b0;
         clkn_q   <= 1'b0;
         tick_q   <= 1'b0;
         ack_q    <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         burst_q  <= burst_d;
         per_a_q  <= per_a_d;
         duty_a_q <= duty_a_d;
         dead_a_q <= dead_a_d;
         ph_a_q   <= ph_a_d;
         per_p_q  <= per_p_d;
         duty_p_q <= duty_p_d;
         dead_p_q <= dead_p_d;
         ph_p_q   <= ph_p_d;
         dirty_q  <= dirty_d;
         clk_q    <= clk_d;
         clkn_q   <= clkn_d;
         tick_q   <= tick_d;
         ack_q    <= ack_d;
         busy_q   <= busy_d;
      end
   end

   for (genvar g = 0; g < N_LIGHT; g++) begin : g_light
      mod_phase_cmp #(.CNT_W(CNT_W)) u_cmp (
         .clk  (USER_CLOCK),
         .rst  (RESET),
         .en   (en_c),
         .cnt  (cnt_q),
         .per  (per_a_q),
         .ph   (ph_a_q[g*CNT_W +: CNT_W]),
         .duty (duty_a_q),
         .clkl (clkl[g])
      );
   end

   assign CLK_MOD     = clk_q;
   assign CLKN_MOD    = clkn_q;
   assign CLKL_MOD    = clkl;
   assign PERIOD_TICK = tick_q;
   assign CFG_ACK     = ack_q;
   assign BUSY        = busy_q;

endmodule

// File: tb/tb_mod_clkgen_multi.sv
// Directed and randomized stimulus for mod_clkgen_multi, checked every cycle
// against a cycle-level behavioural model of the generator.
module tb_mod_clkgen_multi;

   logic        clk = 1'b0;
   logic        rst, drain_b, cfg_load, start;
   logic [1:0]  mode;
   logic [7:0]  period, duty;
   logic [2:0]  dead;
   logic [15:0] phase;
   logic [15:0] blen;
   logic        clk_mod, clkn_mod, tick, ack, busy;
   logic [1:0]  clkl;

   int n_checks = 0;
   int n_fail   = 0;

   // Model state: m_st 0 = idle, 1 = continuous, 2 = burst.
   int a_per, a_duty, a_dead, p_per, p_duty, p_dead;
   int a_ph[2];
   int p_ph[2];
   bit p_dirty;
   int m_st, m_cnt, m_left;
   bit e_clk, e_clkn, e_tick, e_ack, e_busy;
   logic [1:0] e_clkl;

   mod_clkgen_multi #(.CNT_W(8), .N_LIGHT(2), .DT_W(3), .BURST_W(16)) dut (
      .USER_CLOCK  (clk),
      .RESET       (rst),
      .MODE        (mode),
      .PERIOD      (period),
      .DUTY        (duty),
      .DEAD        (dead),
      .PHASE       (phase),
      .BURST_LEN   (blen),
      .CFG_LOAD    (cfg_load),
      .START       (start),
      .DRAIN_B     (drain_b),
      .CLK_MOD     (clk_mod),
      .CLKN_MOD    (clkn_mod),
      .CLKL_MOD    (clkl),
      .PERIOD_TICK (tick),
      .CFG_ACK     (ack),
      .BUSY        (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
      end
   endtask

   function automatic void model_rst();
      a_per = 3; a_duty = 2; a_dead = 0; a_ph[0] = 0; a_ph[1] = 0;
      p_per = 3; p_duty = 2; p_dead = 0; p_ph[0] = 0; p_ph[1] = 0;
      p_dirty = 1'b0;
      m_st = 0; m_cnt = 0; m_left = 0;
      e_clk = 0; e_clkn = 0; e_tick = 0; e_ack = 0; e_busy = 0; e_clkl = 2'b00;
   endfunction

   // One rising edge of the reference: outputs decoded from the pre-edge count.
   function automatic void model_step();
      bit running, on, wrap;
      int cp, cd, cph[2];
      if (rst) begin
         model_rst();
         return;
      end
      running = (m_st != 0);
      on      = running && drain_b;
      wrap    = running && (m_cnt == a_per);
      e_clk   = on && (m_cnt < a_duty);
      e_clkn  = on && (m_cnt >= a_duty + a_dead) && (m_cnt <= a_per - a_dead);
      for (int i = 0; i < 2; i++)
         e_clkl[i] = on && (((m_cnt - a_ph[i] + a_per + 1) % (a_per + 1)) < a_duty);
      e_tick  = on && (m_cnt == a_per);
      e_busy  = on;
      e_ack   = 1'b0;

      cp = (int'(period) < 3) ? 3 : int'(period);
      cd = (int'(duty) < 1) ? 1 : ((int'(duty) > cp) ? cp : int'(duty));
      for (int i = 0; i < 2; i++) begin
         cph[i] = int'(phase[i*8 +: 8]);
         if (cph[i] > cp) cph[i] = 0;
      end
      if (cfg_load && wrap) begin
         a_per = cp; a_duty = cd; a_dead = int'(dead); a_ph[0] = cph[0]; a_ph[1] = cph[1];
         p_dirty = 1'b0;
         e_ack = 1'b1;
      end else begin
         if (p_dirty && (wrap || !running)) begin
            a_per = p_per; a_duty = p_duty; a_dead = p_dead; a_ph[0] = p_ph[0]; a_ph[1] = p_ph[1];
            p_dirty = 1'b0;
            e_ack = 1'b1;
         end
         if (cfg_load) begin
            p_per = cp; p_duty = cd; p_dead = int'(dead); p_ph[0] = cph[0]; p_ph[1] = cph[1];
            p_dirty = 1'b1;
         end
      end

      if (!drain_b) begin
         m_st = 0; m_cnt = 0; m_left = 0;
      end else if (m_st == 0) begin
         if (mode == 2'd1) m_st = 1;
         else if (mode == 2'd2 && start && blen != 0) begin
            m_st = 2; m_left = int'(blen);
         end
      end else if (wrap) begin
         m_cnt = 0;
         if (m_st == 1 && mode != 2'd1) m_st = 0;
         if (m_st == 2) begin
            m_left--;
            if (m_left == 0) m_st = 0;
         end
      end else begin
         m_cnt++;
      end
   endfunction

   // Advance one clock, compare at #1 after the edge, release one-shot inputs.
   task automatic cycle();
      @(posedge clk);
      model_step();
      #1;
      chk("clk_mod",  32'(clk_mod),  32'(e_clk));
      chk("clkn_mod", 32'(clkn_mod), 32'(e_clkn));
      chk("clkl_mod", 32'(clkl),     32'(e_clkl));
      chk("tick",     32'(tick),     32'(e_tick));
      chk("cfg_ack",  32'(ack),      32'(e_ack));
      chk("busy",     32'(busy),     32'(e_busy));
      chk("overlap",  32'(clk_mod & clkn_mod), 32'(0));
      @(negedge clk);
      cfg_load = 1'b0;
      start    = 1'b0;
      rst      = 1'b0;
   endtask

   task automatic run_to_cnt(input int target);
      for (int i = 0; i < 600 && m_cnt != target; i++) cycle();
      chk("reach_cnt", 32'(m_cnt), 32'(target));
   endtask

   initial begin
      rst = 1'b1; drain_b = 1'b1; cfg_load = 1'b0; start = 1'b0; mode = 2'd0;
      period = 8'd3; duty = 8'd2; dead = 3'd0; phase = 16'h0; blen = 16'd0;
      model_rst();
      cycle();
      rst = 1'b1;
      cycle();

      // Basic decode with two phase offsets.
      period = 8'd9; duty = 8'd5; dead = 3'd1; phase = {8'd3, 8'd0}; cfg_load = 1'b1;
      cycle();
      mode = 2'd1;
      repeat (25) cycle();

      // Phase wrap, duty and period clamping.
      phase = {8'd8, 8'd0}; cfg_load = 1'b1;
      repeat (22) cycle();
      duty = 8'd0; cfg_load = 1'b1;
      repeat (14) cycle();
      period = 8'd1; duty = 8'd5; cfg_load = 1'b1;
      repeat (14) cycle();

      // Mid-period reconfiguration.
      period = 8'd9; duty = 8'd5; phase = {8'd3, 8'd0}; cfg_load = 1'b1;
      repeat (12) cycle();
      run_to_cnt(5);
      period = 8'd4; cfg_load = 1'b1;
      repeat (20) cycle();

      // Burst of three with a repeated START mid-burst.
      mode = 2'd0;
      repeat (12) cycle();
      blen = 16'd3; mode = 2'd2; start = 1'b1;
      cycle();
      repeat (6) cycle();
      start = 1'b1;
      repeat (25) cycle();

      // DRAIN_B hold during continuous run.
      mode = 2'd1;
      repeat (3) cycle();
      run_to_cnt(2);
      drain_b = 1'b0;
      repeat (3) cycle();
      drain_b = 1'b1;
      repeat (12) cycle();

      // Reset mid-burst, then invalid mode.
      mode = 2'd2; start = 1'b1; blen = 16'd4;
      repeat (3) cycle();
      mode = 2'd0;
      repeat (10) cycle();
      mode = 2'd2; start = 1'b1;
      repeat (7) cycle();
      rst = 1'b1;
      cycle();
      mode = 2'd3; start = 1'b1;
      repeat (10) cycle();

      // Randomized traffic.
      for (int n = 0; n < 15000; n++) begin
         rst     = ($urandom % 500) == 0;
         drain_b = ($urandom % 80) != 0;
         if (($urandom % 40) == 0) mode = 2'($urandom % 4);
         start = ($urandom % 20) == 0;
         blen  = 16'($urandom % 5);
         if (($urandom % 25) == 0) begin
            cfg_load = 1'b1;
            period   = (($urandom % 20) == 0) ? 8'd255 : 8'($urandom % 16);
            duty     = 8'($urandom % (int'(period) + 3));
            dead     = 3'($urandom % 8);
            phase    = {8'($urandom % (int'(period) + 3)), 8'($urandom % (int'(period) + 3))};
         end
         cycle();
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mod_clkgen_multi.md
# mod_clkgen_multi

Parametrised successor to the counter-based modulation clock generator. It produces the complementary CLK/CLKN demodulation pair and N_LIGHT independently phase-shifted light-source clocks (CLKL) from one fabric clock. Period, duty, dead time and phase are runtime-programmable. Configuration is double-buffered and takes effect only at period boundaries, so no runt pulses occur. Continuous and counted-burst modes are supported, with DRAIN_B gating. It sits between the PLL/BUFG clock source and the ODDR2 output forwarders, which stay at top level.

## Interface
- CNT_W, 8: period/duty/phase counter width
- N_LIGHT, 2: number of CLKL channels
- DT_W, 3: dead-time field width
- BURST_W, 16: burst period-count width

- USER_CLOCK  in  1  sole clock; all logic is rising-edge
- RESET  in  1  synchronous, active-high
- MODE  in  2  0 off, 1 continuous, 2 burst, 3 treated as off
- PERIOD  in  CNT_W  period = PERIOD+1 cycles; values <3 are clamped to 3
- DUTY  in  CNT_W  CLK high cycles; clamped to [1, PERIOD]
- DEAD  in  DT_W  non-overlap cycles on each side of CLKN
- PHASE  in  N_LIGHT*CNT_W  CLKL[i] offset in cycles (slice i); a value > PERIOD is treated as 0
- BURST_LEN  in  BURST_W  number of periods per burst
- CFG_LOAD  in  1  pulse; captures PERIOD/DUTY/DEAD/PHASE into the pending bank
- START  in  1  pulse; starts a burst (MODE=2 only)
- DRAIN_B  in  1  active-low hold
- CLK_MOD  out  1  demodulation clock
- CLKN_MOD  out  1  non-overlapping complement
- CLKL_MOD  out  N_LIGHT  light-source clocks
- PERIOD_TICK  out  1  one-cycle pulse marking the last cycle of each period
- CFG_ACK  out  1  one-cycle pulse when the pending bank becomes active
- BUSY  out  1  state ≠ IDLE

## Operation
- State machine: IDLE, RUN, BURST.
  - IDLE→RUN when MODE=1 and DRAIN_B=1.
  - IDLE→BURST on START with MODE=2, DRAIN_B=1 and BURST_LEN≠0. START is ignored in any other case.
  - RUN→IDLE at the period wrap after MODE≠1.
  - BURST→IDLE at the wrap that completes BURST_LEN periods. START during BURST is ignored.
- DRAIN_B=0: from any state, go to IDLE the next cycle. The burst is aborted and the counter is cleared.
- Counter: cnt runs 0..P, where P is the active PERIOD. It wraps to 0. It is held at 0 in IDLE.
- Waveform decode, with D and T the active duty and dead time:
  - CLK_MOD = (cnt < D).
  - CLKN_MOD = (cnt ≥ D+T) and (cnt ≤ P−T). If that window is empty, CLKN_MOD stays low.
  - CLKL_MOD[i] = (r_i < D), where r_i = cnt−PH_i if cnt ≥ PH_i, else cnt+P+1−PH_i.
- Decode width: use CNT_W+1-bit sums throughout so there is no overflow at P = 2^CNT_W − 1.
- Config banks:
  - CFG_LOAD writes the pending bank.
  - The active bank loads from pending on the wrap cycle (cnt==P) if pending is dirty. In IDLE it loads on the next cycle.
  - CFG_LOAD coinciding with a wrap: the inputs load directly into active and apply to the next period.
  - CFG_ACK pulses on the cycle after the active load.
- Reset values:
  - All outputs 0.
  - State IDLE, cnt 0.
  - Active and pending banks: PERIOD=3, DUTY=2, DEAD=0, PHASE=0. Pending not dirty.
  - Burst count 0.

## Timing
- All outputs are registered; latency from the counter value is 1 cycle.
- MODE=1 sampled in IDLE: cnt=0 on the next cycle, and CLK_MOD first goes high 2 cycles after MODE is first sampled.
- PERIOD_TICK is high on the output cycle that corresponds to cnt==P.
- DRAIN_B falling: all outputs are low 1 cycle later.
- DRAIN_B rising with MODE=1: the restart follows the IDLE→RUN timing above.
- RESET mid-period: outputs are low on the next cycle, with no partial pulse.
- After a mode change to off, the current period completes in full; the final outputs match a normal period.

## Structure
- Package mod_gen_pkg holds:
  - MODE encodings.
  - The state enum.
  - Reset constants RST_PERIOD=3, RST_DUTY=2, MIN_PERIOD=3.
- Sub-module mod_phase_cmp: registered phase-shifted compare (cnt, P, PH, D → CLKL bit). Instantiate it N_LIGHT times with a generate loop.
- The top holds the FSM, counter, config banks, clamping and the CLK/CLKN decode.

## Test plan
- Waveform decode: PERIOD=9, DUTY=5, DEAD=1, PHASE={0,3}, MODE=1.
  - Period is 10 cycles.
  - CLK high for cnt 0–4; CLKN high for cnt 6–8.
  - CLKL[0] equals CLK; CLKL[1] high for cnt 3–7.
  - No cycle has CLK and CLKN both high.
- Phase wrap and clamping: PHASE[1]=8 with the same settings gives CLKL[1] high for cnt 8,9,0,1,2. DUTY=0 is clamped to 1. PERIOD=1 is clamped to 3.
- Mid-period reconfiguration: CFG_LOAD with PERIOD=4 at cnt=5. The current period still lasts 10 cycles, the next lasts 5, and CFG_ACK fires once at the boundary.
- Burst: BURST_LEN=3, MODE=2, START. Exactly 3 PERIOD_TICKs occur, then BUSY falls and outputs stay 0. A second START mid-burst does not extend it.
- DRAIN_B: pull low at cnt=2 during RUN. Outputs are 0 on the next cycle and BUSY falls. On release, CLK_MOD rises 2 cycles later with cnt restarting from 0.
- Reset and invalid MODE: RESET mid-burst gives all outputs 0 next cycle and the active bank returns to reset values. MODE=3 keeps the block in IDLE.
